// File: rtl/wb_stage_buffer.sv
// wb_stage_buffer: DEPTH-entry in-order MEM/WB queue with valid/ready on both
// sides, synchronous flush, write-back data select and a youngest-first
// forwarding lookup over the stored entries. State updates on the falling edge.
module wb_stage_buffer #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_mem_data,
    input  logic [DATA_W-1:0]            in_alu_result,
    input  logic [REG_ADDR_W-1:0]        in_rd,
    input  logic                         in_mem_to_reg,
    input  logic                         in_reg_write,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_wb_data,
    output logic [REG_ADDR_W-1:0]        out_rd,
    output logic                         out_reg_write,
    input  logic [REG_ADDR_W-1:0]        fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic [DATA_W-1:0]     mem_data_reg   [DEPTH];
    logic [DATA_W-1:0]     alu_result_reg [DEPTH];
    logic [REG_ADDR_W-1:0] rd_reg         [DEPTH];
    logic                  mem_to_reg_reg [DEPTH];
    logic                  reg_write_reg  [DEPTH];

    // Per-entry selected write-back data and forwarding match
    logic [DATA_W-1:0]     entry_wb       [DEPTH];
    logic                  entry_match    [DEPTH];

    logic [PTR_W-1:0]      head_reg, head_next;
    logic [PTR_W-1:0]      tail_reg, tail_next;
    logic [CNT_W-1:0]      count_reg, count_next;

    logic                  push;
    logic                  pop;
    int                    fwd_idx;

    // Wrap a pointer from DEPTH-1 back to 0 so any DEPTH works
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    // Handshake status depends only on registered occupancy
    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_wb[gi]    = mem_to_reg_reg[gi] ? mem_data_reg[gi] : alu_result_reg[gi];
            // R0 is hardwired, so it is never worth forwarding
            assign entry_match[gi] = reg_write_reg[gi] && (rd_reg[gi] == fwd_addr)
                                     && (rd_reg[gi] != '0);

            // Capture the presented entry into the tail slot on an accepted push
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    mem_data_reg[gi]   <= '0;
                    alu_result_reg[gi] <= '0;
                    rd_reg[gi]         <= '0;
                    mem_to_reg_reg[gi] <= 1'b0;
                    reg_write_reg[gi]  <= 1'b0;
                end else if (push && !flush && (tail_reg == PTR_W'(gi))) begin
                    mem_data_reg[gi]   <= in_mem_data;
                    alu_result_reg[gi] <= in_alu_result;
                    rd_reg[gi]         <= in_rd;
                    mem_to_reg_reg[gi] <= in_mem_to_reg;
                    reg_write_reg[gi]  <= in_reg_write;
                end
            end
        end
    endgenerate

    // Next pointers and occupancy; flush overrides any push or pop
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push)
                tail_next = ptr_inc(tail_reg);
            if (pop)
                head_next = ptr_inc(head_reg);
            if (push && !pop)
                count_next = count_reg + CNT_W'(1);
            else if (pop && !push)
                count_next = count_reg - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Head outputs are forced to zero while the queue is empty
    always_comb begin
        out_wb_data   = '0;
        out_rd        = '0;
        out_reg_write = 1'b0;
        if (out_valid) begin
            out_wb_data   = entry_wb[head_reg];
            out_rd        = rd_reg[head_reg];
            out_reg_write = reg_write_reg[head_reg];
        end
    end

    // Walk occupied entries oldest to youngest so the youngest match is kept last
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = int'(head_reg) + i;
            if (fwd_idx >= DEPTH)
                fwd_idx = fwd_idx - DEPTH;
            if ((i < int'(count_reg)) && entry_match[fwd_idx[PTR_W-1:0]]) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_wb[fwd_idx[PTR_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Directed bench for wb_stage_buffer (DEPTH = 2). Inputs change 1 ns after a
// falling edge and outputs are sampled at the same point.
module tb_wb_stage_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mem_data;
    logic [15:0] in_alu_result;
    logic [2:0]  in_rd;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_wb_data;
    logic [2:0]  out_rd;
    logic        out_reg_write;
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;

    wb_stage_buffer #(.DATA_W(16), .REG_ADDR_W(3), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_data(out_wb_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] mem, input logic [15:0] alu,
                         input logic [2:0] rd, input logic m2r, input logic rw,
                         input logic ordy);
        in_valid      = v;
        in_mem_data   = mem;
        in_alu_result = alu;
        in_rd         = rd;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        out_ready     = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; fwd_addr = 3'd0;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst = 1'b0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_wb_data !== 16'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0000", out_wb_data); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b expected 0", fwd_hit); end
        $display("reset: count=%0d in_ready=%b out_valid=%b", count, in_ready, out_valid);
    endtask

    task automatic test_wb_select();
        drive(1'b1, 16'hBEEF, 16'h1234, 3'd5, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (out_wb_data !== 16'hBEEF) begin errors++; $display("FAIL wbsel_mem_data: got %h expected beef", out_wb_data); end
        checks++; if (out_rd !== 3'd5) begin errors++; $display("FAIL wbsel_rd: got %0d expected 5", out_rd); end
        checks++; if (out_reg_write !== 1'b1) begin errors++; $display("FAIL wbsel_reg_write: got %b expected 1", out_reg_write); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL wbsel_count: got %0d expected 1", count); end
        $display("wb_select mem: out_wb_data=%h out_rd=%0d", out_wb_data, out_rd);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL wbsel_empty_reg_write: got %b expected 0", out_reg_write); end
        drive(1'b1, 16'hBEEF, 16'h1234, 3'd5, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (out_wb_data !== 16'h1234) begin errors++; $display("FAIL wbsel_alu: got %h expected 1234", out_wb_data); end
        $display("wb_select alu: out_wb_data=%h", out_wb_data);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL wbsel_drain: got %0d expected 0", count); end
    endtask

    task automatic test_fill_wrap();
        drive(1'b1, 16'h0, 16'h0001, 3'd1, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0, 16'h0002, 3'd2, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_count: got %0d expected 2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        drive(1'b1, 16'h0, 16'h0003, 3'd3, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_refuse_count: got %0d expected 2", count); end
        checks++; if (out_wb_data !== 16'h0001) begin errors++; $display("FAIL fill_head_a: got %h expected 0001", out_wb_data); end
        $display("fill: count=%0d head=%h", count, out_wb_data);
        // Full: only the pop of A happens even with C presented
        drive(1'b1, 16'h0, 16'h0003, 3'd3, 1'b0, 1'b1, 1'b1);
        step();
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL wrap_pop_a_count: got %0d expected 1", count); end
        checks++; if (out_wb_data !== 16'h0002) begin errors++; $display("FAIL wrap_head_b: got %h expected 0002", out_wb_data); end
        step();
        checks++; if (out_wb_data !== 16'h0003) begin errors++; $display("FAIL wrap_head_c: got %h expected 0003", out_wb_data); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL wrap_c_count: got %0d expected 1", count); end
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %b expected 0", out_valid); end
        $display("wrap: drained, count=%0d", count);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h0, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 16'h0, 16'(i), 3'd1, 1'b0, 1'b1, 1'b1);
            checks++; if (out_wb_data !== 16'(i - 1)) begin errors++; $display("FAIL b2b_head_before[%0d]: got %h expected %h", i, out_wb_data, 16'(i - 1)); end
            step();
            checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count); end
            checks++; if (out_wb_data !== 16'(i)) begin errors++; $display("FAIL b2b_head_after[%0d]: got %h expected %h", i, out_wb_data, 16'(i)); end
            $display("b2b %0d: count=%0d head=%h", i, count, out_wb_data);
        end
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", count); end
    endtask

    task automatic test_forwarding();
        drive(1'b1, 16'h0, 16'h00AA, 3'd3, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0, 16'h00BB, 3'd3, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd4, 1'b0, 1'b1, 1'b0);
        fwd_addr = 3'd3; #1;
        checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_young_hit: got %b expected 1", fwd_hit); end
        checks++; if (fwd_data !== 16'h00BB) begin errors++; $display("FAIL fwd_young_data: got %h expected 00bb", fwd_data); end
        fwd_addr = 3'd4; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss_hit: got %b expected 0", fwd_hit); end
        checks++; if (fwd_data !== 16'h0) begin errors++; $display("FAIL fwd_miss_data: got %h expected 0000", fwd_data); end
        $display("fwd: youngest/miss checked");
        // Pop the old entry; the young one still answers for r3
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        fwd_addr = 3'd3;
        step();
        checks++; if (fwd_data !== 16'h00BB || fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_after_pop: got hit=%b data=%h expected hit=1 data=00bb", fwd_hit, fwd_data); end
        drive(1'b1, 16'h0, 16'h00DD, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        fwd_addr = 3'd0; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_r0: got %b expected 0", fwd_hit); end
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h0, 16'h00EE, 3'd6, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        fwd_addr = 3'd6; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_no_reg_write: got %b expected 0", fwd_hit); end
        fwd_addr = 3'd3; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_popped_gone: got %b expected 0", fwd_hit); end
        $display("fwd: r0/no-write/popped checked, count=%0d", count);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(); step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL fwd_drain: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0, 16'h0011, 3'd1, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0, 16'h0022, 3'd2, 1'b0, 1'b1, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 16'h0, 16'h0077, 3'd7, 1'b0, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_input_dropped: got %0d expected 0", count); end
        drive(1'b1, 16'h0, 16'h0055, 3'd5, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (out_wb_data !== 16'h0055) begin errors++; $display("FAIL flush_restart: got %h expected 0055", out_wb_data); end
        $display("flush: count after restart=%0d head=%h", count, out_wb_data);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 16'h0, 16'h0101, 3'd2, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0, 16'h0202, 3'd2, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        fwd_addr = 3'd2;
        #1;
        checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL midrst_pre_hit: got %b expected 1", fwd_hit); end
        #1 rst = 1'b1;
        #1;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_wb_data !== 16'h0) begin errors++; $display("FAIL midrst_wb_data: got %h expected 0000", out_wb_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL midrst_fwd_hit: got %b expected 0", fwd_hit); end
        $display("midstream reset: count=%0d out_valid=%b", count, out_valid);
        step();
        rst = 1'b0;
        drive(1'b1, 16'hCAFE, 16'h0, 3'd4, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (count !== 2'd1 || out_wb_data !== 16'hCAFE) begin errors++; $display("FAIL midrst_first_push: got count=%0d data=%h expected count=1 data=cafe", count, out_wb_data); end
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        step();
    endtask

    initial begin
        test_reset();
        test_wb_select();
        test_fill_wrap();
        test_back_to_back();
        test_forwarding();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
